// File: rtl/alu_share_arbiter_if.sv
// Bus bundle for alu_share_arbiter: two requester ports, the shared-ALU
// connection and the response channel. The arbiter uses the slave modport and
// the surrounding environment uses master.
interface alu_share_arbiter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [3:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [3:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             busy;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req1_ready,
        output alu_op, alu_a, alu_b,
        input  alu_result,
        output rsp_valid, rsp_id, rsp_result, busy,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req1_ready,
        input  alu_op, alu_a, alu_b,
        output alu_result,
        input  rsp_valid, rsp_id, rsp_result, busy,
        output rsp_ready
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Two-port arbiter in front of one shared combinational ALU.
// One operation in flight: IDLE (accept) -> EXEC (drive ALU, capture) -> RESP.
// Build option ALU_ARB_RR_EN: round-robin arbitration; when undefined, port 0
// has fixed priority with a starvation counter that lets port 1 through after
// STARVE_LIMIT consecutive port-0 wins.
module alu_share_arbiter #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               reset,
    alu_share_arbiter_if.slave bus
);
    localparam logic [3:0] OpAdd = 4'b0010;
    localparam logic [3:0] OpMax = 4'b0110;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result_q;
    logic             id_q;

    logic             grant0;
    logic             grant1;
    logic             accept;

`ifdef ALU_ARB_RR_EN
    // Port granted most recently; reset value 1 gives port 0 the first turn.
    logic last_q;

    // Round-robin winner selection: on contention the port not granted last wins.
    always_comb begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            grant0 = last_q;
            grant1 = ~last_q;
        end
    end

    // Pointer follows every accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (accept) begin
            last_q <= grant1;
        end
    end
`else
    localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

    logic [CntW-1:0] starve_q;
    logic            starved;

    assign starved = (starve_q == Limit);

    // Fixed priority to port 0 unless port 1 has waited out the limit.
    always_comb begin
        grant0 = bus.req0_valid && !(bus.req1_valid && starved);
        grant1 = bus.req1_valid && !(bus.req0_valid && !starved);
    end

    // Count port-0 wins taken while port 1 was waiting; any other grant clears.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
        end else if (accept) begin
            if (grant0 && bus.req1_valid) begin
                starve_q <= starved ? starve_q : starve_q + 1'b1;
            end else begin
                starve_q <= '0;
            end
        end
    end
`endif

    // Readies only in IDLE and never while reset is applied.
    assign bus.req0_ready = (state_q == StIdle) && !reset && grant0;
    assign bus.req1_ready = (state_q == StIdle) && !reset && grant1;
    assign accept         = bus.req0_ready || bus.req1_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StExec;
            StExec:  state_d = StResp;
            StResp:  if (bus.rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Operation capture on accept and result capture at the end of EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= OpAdd;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= 1'b0;
            result_q <= '0;
        end else begin
            if (accept) begin
                op_q <= grant1 ? bus.req1_op : bus.req0_op;
                a_q  <= grant1 ? bus.req1_a : bus.req0_a;
                b_q  <= grant1 ? bus.req1_b : bus.req0_b;
                id_q <= grant1;
            end
            if (state_q == StExec) begin
                result_q <= bus.alu_result;
            end
        end
    end

    // ALU drive: idle value is ADD 0,0; unknown op codes execute as ADD.
    always_comb begin
        bus.alu_op = OpAdd;
        bus.alu_a  = '0;
        bus.alu_b  = '0;
        if (state_q == StExec) begin
            bus.alu_op = (op_q <= OpMax) ? op_q : OpAdd;
            bus.alu_a  = a_q;
            bus.alu_b  = b_q;
        end
    end

    assign bus.rsp_valid  = (state_q == StResp);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_result = result_q;
    assign bus.busy       = (state_q != StIdle);
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: stimulus pushes expected responses,
// a monitor pops them on every response handshake.
module tb_alu_share_arbiter;
    localparam int unsigned WIDTH        = 32;
    localparam int unsigned STARVE_LIMIT = 4;

    typedef struct packed {
        logic             id;
        logic [WIDTH-1:0] res;
    } rsp_t;

    typedef struct {
        logic             port;
        logic [3:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] r;
    } vec_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    rsp_t exp_q[$];
    vec_t vecs[7];
    logic exp_order[10];

    alu_share_arbiter_if #(.WIDTH(WIDTH)) bus ();

    alu_share_arbiter #(
        .WIDTH       (WIDTH),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU; unsupported codes give a marker value.
    always_comb begin
        case (bus.alu_op)
            4'b0000: bus.alu_result = bus.alu_a & bus.alu_b;
            4'b0001: bus.alu_result = bus.alu_a | bus.alu_b;
            4'b0010: bus.alu_result = bus.alu_a + bus.alu_b;
            4'b0011: bus.alu_result = bus.alu_a - bus.alu_b;
            4'b0100: bus.alu_result = bus.alu_a ^ bus.alu_b;
            4'b0101: bus.alu_result = bus.alu_a << bus.alu_b[4:0];
            4'b0110: bus.alu_result = bus.alu_a >> bus.alu_b[4:0];
            default: bus.alu_result = 32'hDEAD_BEEF;
        endcase
    end

    function automatic void check(input string name, input logic [WIDTH-1:0] act,
                                  input logic [WIDTH-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    task automatic drive_req(input logic port, input logic valid, input logic [3:0] op,
                             input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (port) begin
            bus.req1_valid = valid;
            bus.req1_op    = op;
            bus.req1_a     = a;
            bus.req1_b     = b;
        end else begin
            bus.req0_valid = valid;
            bus.req0_op    = op;
            bus.req0_a     = a;
            bus.req0_b     = b;
        end
    endtask

    // Present a request until accepted, then drop it on the following cycle.
    // Returns at the falling edge of the EXEC cycle.
    task automatic issue(input logic port, input logic [3:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] r,
                         input bit expect_rsp);
        bit   got;
        rsp_t e;
        got = 1'b0;
        @(negedge clk);
        drive_req(port, 1'b1, op, a, b);
        for (int i = 0; i < 20; i++) begin
            #1;
            if (port ? bus.req1_ready : bus.req0_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (got) begin
            if (expect_rsp) begin
                e.id  = port;
                e.res = r;
                exp_q.push_back(e);
            end
        end else begin
            bad++;
            $display("FAIL accept_timeout: port %0d got no ready in 20 cycles, want ready", port);
        end
        @(negedge clk);
        drive_req(port, 1'b0, 4'b0000, '0, '0);
    endtask

    // Monitor: every response handshake must match the head of the queue.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!reset && bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp: got id=%0d res=%0h want no response",
                             bus.rsp_id, bus.rsp_result);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_id", bus.rsp_id, e.id);
                    check("rsp_result", bus.rsp_result, e.res);
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.rsp_ready = 1'b1;
        drive_req(1'b0, 1'b0, 4'b0000, '0, '0);
        drive_req(1'b1, 1'b0, 4'b0000, '0, '0);

        vecs = '{
            '{1'b1, 4'b0000, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F},
            '{1'b0, 4'b0001, 32'h0000_1200, 32'h0034_0000, 32'h0034_1200},
            '{1'b1, 4'b0100, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F},
            '{1'b0, 4'b0101, 32'h0000_0003, 32'h0000_0004, 32'h0000_0030},
            '{1'b1, 4'b0110, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001},
            '{1'b0, 4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000},
            '{1'b0, 4'b0011, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF}
        };
`ifdef ALU_ARB_RR_EN
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif

        // Reset state, and no ready while reset is applied.
        repeat (2) @(negedge clk);
        #1;
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_rsp_id", bus.rsp_id, 1'b0);
        check("rst_rsp_result", bus.rsp_result, '0);
        check("rst_alu_op", bus.alu_op, 4'b0010);
        check("rst_alu_a", bus.alu_a, '0);
        drive_req(1'b0, 1'b1, 4'b0010, 32'd1, 32'd1);
        #1;
        check("rst_req0_ready", bus.req0_ready, 1'b0);
        drive_req(1'b0, 1'b0, 4'b0000, '0, '0);
        @(negedge clk);
        reset = 1'b0;

        // Single ADD 5+7 with cycle-accurate latency.
        issue(1'b0, 4'b0010, 32'd5, 32'd7, 32'd12, 1'b1);
        #1;
        check("t1_busy", bus.busy, 1'b1);
        check("t1_alu_op", bus.alu_op, 4'b0010);
        check("t1_alu_a", bus.alu_a, 32'd5);
        check("t1_alu_b", bus.alu_b, 32'd7);
        check("t1_rsp_valid", bus.rsp_valid, 1'b0);
        @(negedge clk);
        #1;
        check("t2_rsp_valid", bus.rsp_valid, 1'b1);
        @(negedge clk);
        #1;
        check("t3_busy", bus.busy, 1'b0);
        check("t3_alu_a", bus.alu_a, '0);

        // Operation table across both ports.
        foreach (vecs[i]) begin
            issue(vecs[i].port, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, 1'b1);
        end
        repeat (2) @(negedge clk);

        // Back-pressured SUB on port 1; port 0 waits, then withdraws.
        bus.rsp_ready = 1'b0;
        issue(1'b1, 4'b0011, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b1);
        drive_req(1'b0, 1'b1, 4'b0010, 32'd1, 32'd1);
        #1;
        check("stall_exec_ready0", bus.req0_ready, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check("stall_rsp_valid", bus.rsp_valid, 1'b1);
            check("stall_rsp_id", bus.rsp_id, 1'b1);
            check("stall_rsp_result", bus.rsp_result, 32'hFFFF_FFFE);
            check("stall_ready0", bus.req0_ready, 1'b0);
        end
        @(negedge clk);
        drive_req(1'b0, 1'b0, 4'b0000, '0, '0);
        bus.rsp_ready = 1'b1;
        #1;
        check("stall_last_result", bus.rsp_result, 32'hFFFF_FFFE);
        @(negedge clk);
        #1;
        check("withdraw_busy", bus.busy, 1'b0);
        check("withdraw_ready0", bus.req0_ready, 1'b0);
        @(negedge clk);
        #1;
        check("withdraw_busy2", bus.busy, 1'b0);

        // Unknown op executes as ADD.
        issue(1'b0, 4'b1111, 32'd2, 32'd3, 32'd5, 1'b1);
        #1;
        check("badop_alu_op", bus.alu_op, 4'b0010);
        check("badop_alu_a", bus.alu_a, 32'd2);
        repeat (2) @(negedge clk);

        // Reset during EXEC drops the operation.
        issue(1'b0, 4'b1111, 32'd9, 32'd9, '0, 1'b0);
        #1;
        check("rstexec_alu_op", bus.alu_op, 4'b0010);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("rstexec_busy", bus.busy, 1'b0);
        check("rstexec_rsp_valid", bus.rsp_valid, 1'b0);
        check("rstexec_rsp_result", bus.rsp_result, '0);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("rstexec_rsp_valid2", bus.rsp_valid, 1'b0);
        check("rstexec_busy2", bus.busy, 1'b0);

        // Both ports continuously valid: one grant every third cycle.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        drive_req(1'b0, 1'b1, 4'b0010, 32'd10, 32'd1);
        drive_req(1'b1, 1'b1, 4'b0011, 32'd100, 32'd1);
        for (int g = 0; g < 10; g++) begin
            rsp_t e;
            #1;
            check("order_ready0", bus.req0_ready, !exp_order[g]);
            check("order_ready1", bus.req1_ready, exp_order[g]);
            e.id  = exp_order[g];
            e.res = exp_order[g] ? 32'd99 : 32'd11;
            exp_q.push_back(e);
            @(negedge clk);
            if (g == 9) begin
                drive_req(1'b0, 1'b0, 4'b0000, '0, '0);
                drive_req(1'b1, 1'b0, 4'b0000, '0, '0);
            end else begin
                repeat (2) @(negedge clk);
            end
        end

        repeat (6) @(negedge clk);
        #1;
        check("drain_pending", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits.
REQ-002 Parameter: STARVE_LIMIT, 4, consecutive port-0 grants allowed while port 1 waits (fixed-priority mode only).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 reqN_valid  input  1  (N=0,1) requester N presents an operation.
REQ-006 reqN_ready  output  1  (N=0,1) arbiter accepts requester N this cycle.
REQ-007 reqN_op  input  4  (N=0,1) ALU operation code: 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 XOR, 0101 SLL, 0110 SRL.
REQ-008 reqN_a, reqN_b  input  WIDTH  (N=0,1) operands.
REQ-009 alu_op  output  4  operation driven to the shared ALU.
REQ-010 alu_a, alu_b  output  WIDTH  operands driven to the shared ALU.
REQ-011 alu_result  input  WIDTH  combinational result from the shared ALU.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  consumer takes response.
REQ-014 rsp_id  output  1  requester that owns the response.
REQ-015 rsp_result  output  WIDTH  registered ALU result.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM SHALL have states IDLE, EXEC, RESP; IDLE->EXEC on accept, EXEC->RESP unconditionally, RESP->IDLE when rsp_ready=1, else hold RESP.
REQ-018 In IDLE, at most one reqN_ready SHALL be high, and only for the arbitration winner among valid requesters; both low outside IDLE and when no request is valid.
REQ-019 Accept (valid&&ready) SHALL latch op, a, b and requester id into internal registers.
REQ-020 In EXEC, alu_op/alu_a/alu_b SHALL be driven from the latched registers and alu_result SHALL be captured into rsp_result at the end of the cycle.
REQ-021 Outside EXEC, alu_op SHALL be 0010 and alu_a/alu_b SHALL be 0.
REQ-022 Op codes outside the REQ-007 set SHALL be latched and driven as 0010 (ADD).
REQ-023 Latency: accept in cycle T -> rsp_valid=1 in cycle T+2; best-case throughput one operation per 3 cycles.
REQ-024 rsp_valid, rsp_id, rsp_result SHALL remain stable while in RESP until rsp_ready=1.
REQ-025 Fixed priority (default): port 0 wins when both valid, except when the starvation counter equals STARVE_LIMIT, then port 1 wins.
REQ-026 Starvation counter SHALL increment on each port-0 grant with req1_valid=1, clear on any port-1 grant or any grant with req1_valid=0, and saturate at STARVE_LIMIT.
REQ-027 A lone valid requester SHALL win regardless of counter or pointer.
REQ-028 A request deasserted before accept SHALL leave no state change.

Reset
REQ-029 On reset=1 at a clock edge: state IDLE, reqN_ready=0 that cycle, rsp_valid=0, rsp_id=0, rsp_result=0, busy=0, starvation counter 0, RR pointer 1.
REQ-030 Reset in EXEC or RESP SHALL discard the in-flight operation with no response issued.

Configuration
REQ-031 Macro ALU_ARB_RR_EN defined: round-robin arbitration; when both valid, winner is the port not granted last; pointer updates on every accept; starvation counter and STARVE_LIMIT unused.
REQ-032 Macro ALU_ARB_RR_EN undefined: fixed-priority arbitration per REQ-025/026.

Verification
REQ-033 Single req0 ADD a=5 b=7, rsp_ready=1 -> alu_op=0010 in T+1, rsp_valid with rsp_id=0, rsp_result=12 in T+2, busy low in T+3.
REQ-034 Both ports continuously valid, fixed priority, STARVE_LIMIT=4 -> grant order 0,0,0,0,1,0,0,0,0,1.
REQ-035 Same stimulus with ALU_ARB_RR_EN -> grant order 0,1,0,1,...
REQ-036 req1 SUB a=3 b=5, rsp_ready held 0 for 4 cycles -> rsp_valid, rsp_id=1, rsp_result=0xFFFFFFFE stable 5 cycles, no new accept until release.
REQ-037 req0 op=1111 -> alu_op=0010 in EXEC; reset asserted in EXEC -> no rsp_valid, IDLE next cycle.
